// File: rtl/seq_alu_if.sv
// seq_alu_if: handshake and data bundle between the register-read stage,
// the sequential ALU and write-back.
//   master  : drives in_valid/A/B/ALUop and out_ready, observes the rest
//   slave   : the ALU side (accepts operations, presents results)
// Parameter DATA_WIDTH must match the seq_alu instance it connects to.
interface seq_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [3:0]            ALUop;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;
    logic [DATA_WIDTH-1:0] Result_hi;
    logic                  Overflow;
    logic                  CarryOut;
    logic                  Zero;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, Result, Result_hi, Overflow, CarryOut, Zero
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, Result, Result_hi, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered results. Single-cycle logic,
// add/sub/compare and shift ops finish one cycle after acceptance; MULU
// (and DIVU/REMU when SEQ_ALU_DIV_EN is defined) iterate one bit per cycle
// and finish DATA_WIDTH+1 cycles after acceptance.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - seq_alu_if.slave: in_valid/in_ready/A/B/ALUop request side,
//          out_valid/out_ready/Result/Result_hi/Overflow/CarryOut/Zero
// Build option: define SEQ_ALU_DIV_EN to include the restoring divider;
// otherwise opcodes 1110/1111 behave as undefined opcodes.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// BUSY  | iterative op in progress, one step per cycle
// DONE  | out_valid=1, result held until out_ready
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic     clk,
    input logic     rst,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]             op_q, op_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [DATA_WIDTH-1:0]  hi_q, hi_d;
    logic [DATA_WIDTH-1:0]  lo_q, lo_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [DATA_WIDTH-1:0]  result_hi_q, result_hi_d;
    logic                   ovf_q, ovf_d;
    logic                   cry_q, cry_d;
    logic                   zero_q, zero_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    logic                   add_sub;
    logic [DATA_WIDTH-1:0]  b_eff;
    logic [DATA_WIDTH:0]    sum;
    logic                   add_ovf;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic                   alu_ovf;
    logic                   alu_cry;
    logic                   in_iter;

    always_comb begin
        add_sub = (bus.ALUop == OP_SUB) || (bus.ALUop == OP_SLT) || (bus.ALUop == OP_SLTU);
        b_eff   = add_sub ? ~bus.B : bus.B;
        sum     = {1'b0, bus.A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, add_sub};
        add_ovf = (bus.A[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                  (sum[DATA_WIDTH-1] != bus.A[DATA_WIDTH-1]);
        shamt   = bus.B[SHAMT_WIDTH-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_cry = 1'b0;
        case (bus.ALUop)
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_NOR:  alu_res = ~(bus.A | bus.B);
            OP_ADD: begin
                alu_res = sum[DATA_WIDTH-1:0];
                alu_ovf = add_ovf;
                alu_cry = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_res = sum[DATA_WIDTH-1:0];
                alu_ovf = add_ovf;
                alu_cry = ~sum[DATA_WIDTH];   // no carry out of A+~B+1 means A<B
            end
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, ~sum[DATA_WIDTH]};
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, add_ovf ^ sum[DATA_WIDTH-1]};
            OP_SLL:  alu_res = bus.A << shamt;
            OP_SRL:  alu_res = bus.A >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    assign in_iter = (bus.ALUop == OP_MULU) || (bus.ALUop == OP_DIVU) || (bus.ALUop == OP_REMU);
`else
    assign in_iter = (bus.ALUop == OP_MULU);
`endif

    // Iterative step. lo starts as A for both engines: multiplier bits
    // shift out of its bottom, dividend bits shift out of its top while
    // quotient bits shift in. b_q is the multiplicand / divisor.
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH-1:0] step_hi;
    logic [DATA_WIDTH-1:0] step_lo;
`ifdef SEQ_ALU_DIV_EN
    logic [DATA_WIDTH:0]   div_trial;
    logic [DATA_WIDTH:0]   div_diff;
    logic                  div_ge;
`endif

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        step_hi = mul_sum[DATA_WIDTH:1];
        step_lo = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_trial = {hi_q, lo_q[DATA_WIDTH-1]};
        div_diff  = div_trial - {1'b0, b_q};
        div_ge    = ~div_diff[DATA_WIDTH];
        if (op_q != OP_MULU) begin
            step_hi = div_ge ? div_diff[DATA_WIDTH-1:0] : div_trial[DATA_WIDTH-1:0];
            step_lo = {lo_q[DATA_WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        ovf_d       = ovf_q;
        cry_d       = cry_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d       = bus.ALUop;
                    b_d        = bus.B;
                    in_ready_d = 1'b0;
                    if (in_iter) begin
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = bus.A;
                        state_d = BUSY;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        ovf_d       = alu_ovf;
                        cry_d       = alu_cry;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHAMT_WIDTH'(DATA_WIDTH - 1)) begin
                    // Remainder-first ordering only for REMU.
`ifdef SEQ_ALU_DIV_EN
                    if (op_q == OP_REMU) begin
                        result_d    = step_hi;
                        result_hi_d = step_lo;
                    end else begin
                        result_d    = step_lo;
                        result_hi_d = step_hi;
                    end
`else
                    result_d    = (op_q == OP_MULU) ? step_lo : '0;
                    result_hi_d = (op_q == OP_MULU) ? step_hi : '0;
`endif
                    ovf_d       = 1'b0;
                    cry_d       = 1'b0;
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
            cry_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            ovf_q       <= ovf_d;
            cry_q       <= cry_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Result_hi = result_hi_q;
    assign bus.Overflow  = ovf_q;
    assign bus.CarryOut  = cry_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu with hand-computed expectations.
module tb_seq_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.DATA_WIDTH(W)) bus ();
    seq_alu #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Present one op, let it be accepted on the next edge, scramble the
    // operand inputs, then count edges (acceptance edge = 1) to out_valid.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        @(negedge clk);
        bus.ALUop    = op;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 32'hDEAD_BEEF;
        bus.B        = 32'h1357_9BDF;
        bus.ALUop    = 4'b0010;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.ALUop    = 4'b0010;
        bus.A        = 32'h1;
        bus.B        = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.Result !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", bus.Result); end
        checks++; if (bus.Result_hi !== 32'h0) begin errors++; $display("FAIL rst_result_hi got %h want 0", bus.Result_hi); end
        checks++; if ({bus.Overflow, bus.CarryOut, bus.Zero} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {bus.Overflow, bus.CarryOut, bus.Zero}); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_accept got %b want 0", bus.out_valid); end
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (bus.Result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got %h want 80000000", bus.Result); end
        checks++; if ({bus.Overflow, bus.CarryOut, bus.Zero} !== 3'b100) begin errors++; $display("FAIL add_flags got %b want 100", {bus.Overflow, bus.CarryOut, bus.Zero}); end
        take_result();
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        checks++; if ({bus.Result, bus.Overflow, bus.CarryOut, bus.Zero} !== {32'h0, 3'b011}) begin errors++; $display("FAIL add_wrap got %h %b want 00000000 011", bus.Result, {bus.Overflow, bus.CarryOut, bus.Zero}); end
        take_result();
        run_op(4'b0110, 32'h0000_0003, 32'h0000_0005, lat);
        checks++; if (bus.Result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result got %h want fffffffe", bus.Result); end
        checks++; if ({bus.Overflow, bus.CarryOut} !== 2'b01) begin errors++; $display("FAIL sub_flags got %b want 01", {bus.Overflow, bus.CarryOut}); end
        take_result();
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, lat);
        checks++; if ({bus.Result, bus.Overflow, bus.CarryOut} !== {32'h7FFF_FFFF, 2'b10}) begin errors++; $display("FAIL sub_ovf got %h %b want 7fffffff 10", bus.Result, {bus.Overflow, bus.CarryOut}); end
        take_result();
    endtask

    task automatic test_compare_logic();
        logic [3:0]   ops [6] = '{4'b0111, 4'b0101, 4'b0111, 4'b0011, 4'b0100, 4'b0001};
        logic [W-1:0] as  [6] = '{32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
        logic [W-1:0] bs  [6] = '{32'h5, 32'h1, 32'h1, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00};
        logic [W-1:0] exp [6] = '{32'h1, 32'h0, 32'h1, 32'h0FF0_0FF0, 32'h000F_000F, 32'hFFF0_FFF0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat);
            checks++; if (bus.Result !== exp[i]) begin errors++; $display("FAIL cmp_logic[%0d] got %h want %h", i, bus.Result, exp[i]); end
            checks++; if ({bus.Overflow, bus.CarryOut, bus.Zero} !== {2'b00, exp[i] == 32'h0}) begin errors++; $display("FAIL cmp_logic_flags[%0d] got %b", i, {bus.Overflow, bus.CarryOut, bus.Zero}); end
            take_result();
        end
    endtask

    task automatic test_shift();
        int lat;
        run_op(4'b1010, 32'h8000_0000, 32'h0000_001F, lat);
        checks++; if (bus.Result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_result got %h want ffffffff", bus.Result); end
        take_result();
        run_op(4'b1000, 32'h8000_0000, 32'h0000_001F, lat);
        checks++; if (bus.Result !== 32'h0) begin errors++; $display("FAIL sll_result got %h want 0", bus.Result); end
        checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL sll_zero got %b want 1", bus.Zero); end
        take_result();
        run_op(4'b1001, 32'h8000_0000, 32'hFFFF_FFE4, lat);
        checks++; if (bus.Result !== 32'h0800_0000) begin errors++; $display("FAIL srl_result got %h want 08000000", bus.Result); end
        take_result();
    endtask

    task automatic test_mulu();
        int lat;
        run_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0002, lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mulu_latency got %0d want 33", lat); end
        checks++; if ({bus.Result_hi, bus.Result} !== 64'h1_FFFF_FFFE) begin errors++; $display("FAIL mulu_result got %h_%h want 00000001_fffffffe", bus.Result_hi, bus.Result); end
        // Request waiting while the result is held must not be taken.
        bus.in_valid = 1'b1;
        bus.ALUop    = 4'b0000;
        bus.A        = 32'h1;
        bus.B        = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if ({bus.out_valid, bus.in_ready, bus.Result_hi, bus.Result} !== {2'b10, 64'h1_FFFF_FFFE}) begin errors++; $display("FAIL mulu_hold[%0d] got v=%b r=%b %h_%h", i, bus.out_valid, bus.in_ready, bus.Result_hi, bus.Result); end
        end
        bus.in_valid = 1'b0;
        take_result();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL mulu_release got %b want 01", {bus.out_valid, bus.in_ready}); end
        run_op(4'b1100, 32'h0001_0000, 32'h0001_0000, lat);
        checks++; if ({bus.Result_hi, bus.Result, bus.Zero} !== {64'h1_0000_0000, 1'b1}) begin errors++; $display("FAIL mulu_pow2 got %h_%h z=%b", bus.Result_hi, bus.Result, bus.Zero); end
        take_result();
        run_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0002, lat);
        take_result();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        @(negedge clk);
        bus.ALUop    = 4'b1100;
        bus.A        = 32'hFFFF_FFFF;
        bus.B        = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL midrst_hs got %b want 01", {bus.out_valid, bus.in_ready}); end
        checks++; if ({bus.Result_hi, bus.Result} !== 64'h0) begin errors++; $display("FAIL midrst_result got %h_%h want 0", bus.Result_hi, bus.Result); end
        checks++; if ({bus.Overflow, bus.CarryOut, bus.Zero} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {bus.Overflow, bus.CarryOut, bus.Zero}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL midrst_after got %b want 01", {bus.out_valid, bus.in_ready}); end
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        checks++; if ({bus.Result, lat} !== {32'hF000_F000, 32'd1}) begin errors++; $display("FAIL midrst_and got %h lat=%0d want f000f000 lat=1", bus.Result, lat); end
        take_result();
    endtask

    task automatic test_div();
        int lat;
`ifdef SEQ_ALU_DIV_EN
        run_op(4'b1110, 32'd100, 32'd7, lat);
        checks++; if ({bus.Result, bus.Result_hi, lat} !== {32'd14, 32'd2, 32'd33}) begin errors++; $display("FAIL divu got %0d r=%0d lat=%0d want 14 2 33", bus.Result, bus.Result_hi, lat); end
        take_result();
        run_op(4'b1111, 32'd100, 32'd7, lat);
        checks++; if ({bus.Result, bus.Result_hi} !== {32'd2, 32'd14}) begin errors++; $display("FAIL remu got %0d q=%0d want 2 14", bus.Result, bus.Result_hi); end
        take_result();
        run_op(4'b1110, 32'd5, 32'd0, lat);
        checks++; if ({bus.Result, bus.Result_hi, lat} !== {32'hFFFF_FFFF, 32'd5, 32'd33}) begin errors++; $display("FAIL divu_zero got %h r=%h lat=%0d want ffffffff 5 33", bus.Result, bus.Result_hi, lat); end
        take_result();
`else
        run_op(4'b1110, 32'd100, 32'd7, lat);
        checks++; if ({bus.Result, bus.Result_hi, lat} !== {32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL divu_off got %h %h lat=%0d want 0 0 1", bus.Result, bus.Result_hi, lat); end
        take_result();
        run_op(4'b1111, 32'd100, 32'd7, lat);
        checks++; if ({bus.Result, lat} !== {32'd0, 32'd1}) begin errors++; $display("FAIL remu_off got %h lat=%0d want 0 1", bus.Result, lat); end
        take_result();
`endif
    endtask

    task automatic test_undefined();
        int lat;
        run_op(4'b0010, 32'd5, 32'd9, lat);
        take_result();
        run_op(4'b1011, 32'hFFFF_FFFF, 32'h1, lat);
        checks++; if ({bus.Result, bus.Result_hi, bus.Overflow, bus.CarryOut, lat} !== {64'h0, 2'b00, 32'd1}) begin errors++; $display("FAIL undef_1011 got %h %h %b lat=%0d", bus.Result, bus.Result_hi, {bus.Overflow, bus.CarryOut}, lat); end
        take_result();
        run_op(4'b1101, 32'h7FFF_FFFF, 32'h1, lat);
        checks++; if ({bus.Result, bus.Overflow, bus.CarryOut, lat} !== {32'h0, 2'b00, 32'd1}) begin errors++; $display("FAIL undef_1101 got %h %b lat=%0d", bus.Result, {bus.Overflow, bus.CarryOut}, lat); end
        take_result();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.ALUop     = 4'b0010;
        bus.A         = 32'd1;
        bus.B         = 32'd2;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.in_ready, bus.Result} !== {2'b10, 32'd3}) begin errors++; $display("FAIL b2b_first got v=%b r=%b %0d", bus.out_valid, bus.in_ready, bus.Result); end
        bus.A = 32'd10;
        bus.B = 32'd20;
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_gap got %b want 01", {bus.out_valid, bus.in_ready}); end
        @(posedge clk);
        #1;
        checks++; if ({bus.out_valid, bus.Result} !== {1'b1, 32'd30}) begin errors++; $display("FAIL b2b_second got v=%b %0d", bus.out_valid, bus.Result); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_end got %b want 01", {bus.out_valid, bus.in_ready}); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALUop     = '0;
        test_reset();
        test_add_sub();
        test_compare_logic();
        test_shift();
        test_mulu();
        test_reset_mid_busy();
        test_div();
        test_undefined();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
